rep_matrix: RTL and testbench
=============================

REP_MATRIX -- requirements
Module: rep_matrix

Interface
REQ-001 Parameter N, default 5, number of input channels (N >= 2).
REQ-002 Parameter W, default 1, width of each channel in bits (W >= 1).
REQ-003 Parameter CNT_W, default 16, width of the uniform-sample counter (CNT_W >= 2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_data holds a sample.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 in_data  input  N*W  channel i occupies in_data[(N-i)*W-1 -: W]; channel 0 is the MSB field.
REQ-009 out_valid  output  1  out_matrix and out_all_eq hold a result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 out_matrix  output  N*N  pairwise equality matrix.
REQ-012 out_all_eq  output  1  all N channels of the sample were equal.
REQ-013 clr_cnt  input  1  synchronous clear of uniform_cnt.
REQ-014 uniform_cnt  output  CNT_W  count of accepted samples with all channels equal.

Function
REQ-015 Bit N*N-1-(i*N+j) of the result SHALL be 1 iff channel i == channel j; for N=5, W=1 this matches ~{{5{a}},...,{5{e}}} ^ {5{a,b,c,d,e}}.
REQ-016 Diagonal bits SHALL always be 1 and the matrix SHALL be symmetric.
REQ-017 A sample SHALL be accepted when in_valid && in_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-019 The result SHALL be registered; out_valid SHALL rise in the cycle after acceptance (latency 1).
REQ-020 While out_valid && !out_ready, out_matrix, out_all_eq and any optional outputs SHALL hold stable.
REQ-021 If acceptance and consumption coincide, the new result SHALL replace the old one with out_valid staying 1 (full throughput).
REQ-022 If the result is consumed with no new acceptance, out_valid SHALL fall on the next edge.
REQ-023 out_all_eq SHALL be the AND of all matrix bits.
REQ-024 uniform_cnt SHALL increment by 1 on each accepted sample whose channels are all equal.
REQ-025 uniform_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 When clr_cnt and an increment occur in the same cycle, clr_cnt SHALL take priority and uniform_cnt becomes 0.

Reset
REQ-027 When rst_n is asserted low, out_valid, out_matrix, out_all_eq, uniform_cnt and out_popcnt (when present) SHALL become 0 immediately.
REQ-028 Reset asserted mid-operation SHALL discard any held result; the first acceptance after rst_n is released SHALL behave exactly as from power-up.

Configuration
REQ-029 Macro REP_MATRIX_POPCNT_EN.
- When defined: output out_popcnt, width $clog2(N*N+1), SHALL carry the registered count of 1s in out_matrix and follow the same valid/hold rules.
- When undefined: the port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 Package rep_pkg SHALL hold:
- the default N, W and CNT_W constants;
- a function mapping (i, j) to the matrix bit index.
REQ-031 A purely combinational sub-module rep_eq_matrix (in_data -> matrix) SHALL be instantiated; rep_matrix holds all registers, the handshake and the counter.

Verification
REQ-032 The bench SHALL cover the following scenarios (N=5, W=1 unless stated):
- in_data=5'b01101 accepted -> next cycle out_valid=1, out_matrix=0x126B64D, out_all_eq=0, uniform_cnt unchanged; with REP_MATRIX_POPCNT_EN, out_popcnt=13.
- 5'b11111 then 5'b00000, back-to-back with out_ready=1 -> out_matrix=0x1FFFFFF on both cycles, out_all_eq=1, uniform_cnt counts 1 then 2, out_valid continuously 1.
- out_ready=0 after 5'b10101 is accepted, then 5'b01001 offered -> in_ready=0, output holds 5'b10101's result until out_ready=1, then 5'b01001 is accepted.
- CNT_W=3, ten all-equal samples -> uniform_cnt stops at 7; clr_cnt=1 pulsed together with an all-equal acceptance -> uniform_cnt=0.
- N=4, W=8, in_data=0xAA55AA55 -> out_matrix=0xA5A5, out_all_eq=0.
- rst_n pulsed low while out_valid=1 and out_ready=0 -> all outputs 0 asynchronously; no stale result after release.

Source files
------------

// File: rtl/rep_pkg.sv
// rep_pkg -- shared constants and helpers for the rep_matrix block.
//   REP_N_DEF / REP_W_DEF / REP_CNT_W_DEF : default channel count, channel
//                                           width and uniform-counter width.
//   rep_bit_idx(n, i, j)                  : position of the (i, j) equality
//                                           bit in the flattened n*n matrix
//                                           (row 0, column 0 is the MSB).
package rep_pkg;

    localparam int REP_N_DEF     = 5;
    localparam int REP_W_DEF     = 1;
    localparam int REP_CNT_W_DEF = 16;

    function automatic int rep_bit_idx(input int n, input int i, input int j);
        return n * n - 1 - (i * n + j);
    endfunction

endpackage

// File: rtl/rep_eq_matrix.sv
// rep_eq_matrix -- purely combinational pairwise equality matrix.
//   in_data [N*W-1:0] : N channels, channel i at in_data[(N-i)*W-1 -: W]
//                       (channel 0 is the MSB field).
//   matrix  [N*N-1:0] : bit rep_bit_idx(N, i, j) is 1 iff channel i == channel j.
module rep_eq_matrix
    import rep_pkg::*;
#(
    parameter int N = REP_N_DEF,
    parameter int W = REP_W_DEF
) (
    input  logic [N*W-1:0] in_data,
    output logic [N*N-1:0] matrix
);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign matrix[rep_bit_idx(N, i, j)] =
                (in_data[(N-i)*W-1 -: W] == in_data[(N-j)*W-1 -: W]);
        end
    end

endmodule

// File: rtl/rep_matrix.sv
// rep_matrix -- registered pairwise channel-equality matrix with a
// valid/ready handshake and a saturating count of all-equal samples.
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset.
//   in_valid / in_ready   : input handshake; in_ready = !out_valid || out_ready.
//   in_data  [N*W-1:0]    : N channels of W bits, channel 0 in the MSB field.
//   out_valid / out_ready : output handshake; result held while stalled.
//   out_matrix [N*N-1:0]  : pairwise equality matrix of the accepted sample.
//   out_all_eq            : all channels of the accepted sample were equal.
//   out_popcnt            : number of 1s in out_matrix (only when the macro
//                           REP_MATRIX_POPCNT_EN is defined).
//   clr_cnt               : synchronous clear of uniform_cnt (wins over +1).
//   uniform_cnt [CNT_W-1:0]: saturating count of accepted all-equal samples.
module rep_matrix
    import rep_pkg::*;
#(
    parameter int N     = REP_N_DEF,
    parameter int W     = REP_W_DEF,
    parameter int CNT_W = REP_CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*W-1:0]             in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*N-1:0]             out_matrix,
    output logic                       out_all_eq,
    input  logic                       clr_cnt,
`ifdef REP_MATRIX_POPCNT_EN
    output logic [$clog2(N*N+1)-1:0]   out_popcnt,
`endif
    output logic [CNT_W-1:0]           uniform_cnt
);

    logic [N*N-1:0]   matrix_s;
    logic             all_eq_s;
    logic             accept_s;

    logic             valid_d,  valid_q;
    logic [N*N-1:0]   matrix_d, matrix_q;
    logic             all_eq_d, all_eq_q;
    logic [CNT_W-1:0] cnt_d,    cnt_q;

    rep_eq_matrix #(
        .N (N),
        .W (W)
    ) u_eq (
        .in_data (in_data),
        .matrix  (matrix_s)
    );

    assign all_eq_s = &matrix_s;
    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Output register next-state: load on accept, drop valid on a bare consume.
    always_comb begin
        valid_d  = valid_q;
        matrix_d = matrix_q;
        all_eq_d = all_eq_q;
        if (accept_s) begin
            valid_d  = 1'b1;
            matrix_d = matrix_s;
            all_eq_d = all_eq_s;
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Uniform counter next-state: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s && all_eq_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            matrix_q <= {(N*N){1'b0}};
            all_eq_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            valid_q  <= valid_d;
            matrix_q <= matrix_d;
            all_eq_q <= all_eq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_matrix  = matrix_q;
    assign out_all_eq  = all_eq_q;
    assign uniform_cnt = cnt_q;

`ifdef REP_MATRIX_POPCNT_EN
    localparam int PC_W = $clog2(N*N+1);

    logic [PC_W-1:0] popcnt_s;
    logic [PC_W-1:0] popcnt_d, popcnt_q;

    // Population count of the combinational matrix, captured alongside it.
    always_comb begin
        popcnt_s = {PC_W{1'b0}};
        for (int k = 0; k < N*N; k++) begin
            popcnt_s = popcnt_s + {{(PC_W-1){1'b0}}, matrix_s[k]};
        end
    end

    // Popcount register next-state follows the matrix load/hold rule.
    always_comb begin
        popcnt_d = popcnt_q;
        if (accept_s) begin
            popcnt_d = popcnt_s;
        end else begin
            popcnt_d = popcnt_q;
        end
    end

    // Popcount register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt_q <= {PC_W{1'b0}};
        end else begin
            popcnt_q <= popcnt_d;
        end
    end

    assign out_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_rep_matrix.sv
// tb_rep_matrix -- directed bench for rep_matrix with three instances:
//   u_a : N=5, W=1, CNT_W=16  (main function, handshake, reset)
//   u_b : N=5, W=1, CNT_W=3   (counter saturation and clear priority)
//   u_c : N=4, W=8, CNT_W=16  (wide channels)
// Optional popcount output is checked when REP_MATRIX_POPCNT_EN is defined.
`timescale 1ns/1ps
module tb_rep_matrix;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_all_eq, a_clr_cnt;
    logic [4:0]  a_in_data;
    logic [24:0] a_out_matrix;
    logic [15:0] a_uniform_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_all_eq, b_clr_cnt;
    logic [4:0]  b_in_data;
    logic [24:0] b_out_matrix;
    logic [2:0]  b_uniform_cnt;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_all_eq, c_clr_cnt;
    logic [31:0] c_in_data;
    logic [15:0] c_out_matrix;
    logic [15:0] c_uniform_cnt;

`ifdef REP_MATRIX_POPCNT_EN
    logic [4:0] a_out_popcnt;
    logic [4:0] b_out_popcnt;
    logic [4:0] c_out_popcnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rep_matrix #(.N(5), .W(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_matrix(a_out_matrix), .out_all_eq(a_out_all_eq),
        .clr_cnt(a_clr_cnt),
`ifdef REP_MATRIX_POPCNT_EN
        .out_popcnt(a_out_popcnt),
`endif
        .uniform_cnt(a_uniform_cnt)
    );

    rep_matrix #(.N(5), .W(1), .CNT_W(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_matrix(b_out_matrix), .out_all_eq(b_out_all_eq),
        .clr_cnt(b_clr_cnt),
`ifdef REP_MATRIX_POPCNT_EN
        .out_popcnt(b_out_popcnt),
`endif
        .uniform_cnt(b_uniform_cnt)
    );

    rep_matrix #(.N(4), .W(8), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_matrix(c_out_matrix), .out_all_eq(c_out_all_eq),
        .clr_cnt(c_clr_cnt),
`ifdef REP_MATRIX_POPCNT_EN
        .out_popcnt(c_out_popcnt),
`endif
        .uniform_cnt(c_uniform_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 5'b0; a_out_ready = 1'b0; a_clr_cnt = 1'b0;
        b_in_valid = 1'b0; b_in_data = 5'b0; b_out_ready = 1'b0; b_clr_cnt = 1'b0;
        c_in_valid = 1'b0; c_in_data = 32'h0; c_out_ready = 1'b0; c_clr_cnt = 1'b0;

        // Reset state.
        #12;
        check("rst_valid",  a_out_valid,   1'b0);
        check("rst_matrix", a_out_matrix,  25'h0);
        check("rst_all_eq", a_out_all_eq,  1'b0);
        check("rst_cnt",    a_uniform_cnt, 16'h0);
        check("rst_ready",  a_in_ready,    1'b1);
        rst_n = 1'b1;
        step();

        // Mixed sample 01101.
        a_in_valid = 1'b1; a_in_data = 5'b01101; a_out_ready = 1'b1;
        step();
        check("s1_valid",  a_out_valid,   1'b1);
        check("s1_matrix", a_out_matrix,  25'h126B64D);
        check("s1_all_eq", a_out_all_eq,  1'b0);
        check("s1_cnt",    a_uniform_cnt, 16'd0);
`ifdef REP_MATRIX_POPCNT_EN
        check("s1_popcnt", a_out_popcnt,  5'd13);
`endif

        // Back-to-back uniform samples.
        a_in_data = 5'b11111;
        step();
        check("s2a_valid",  a_out_valid,   1'b1);
        check("s2a_matrix", a_out_matrix,  25'h1FFFFFF);
        check("s2a_all_eq", a_out_all_eq,  1'b1);
        check("s2a_cnt",    a_uniform_cnt, 16'd1);
        a_in_data = 5'b00000;
        step();
        check("s2b_valid",  a_out_valid,   1'b1);
        check("s2b_matrix", a_out_matrix,  25'h1FFFFFF);
        check("s2b_all_eq", a_out_all_eq,  1'b1);
        check("s2b_cnt",    a_uniform_cnt, 16'd2);
`ifdef REP_MATRIX_POPCNT_EN
        check("s2b_popcnt", a_out_popcnt,  5'd25);
`endif
        a_in_valid = 1'b0;
        step();
        check("drain_valid", a_out_valid,   1'b0);
        check("drain_cnt",   a_uniform_cnt, 16'd2);

        // Backpressure: 10101 accepted, 01001 stalls.
        a_in_valid = 1'b1; a_in_data = 5'b10101; a_out_ready = 1'b0;
        step();
        check("bp_valid",  a_out_valid,  1'b1);
        check("bp_matrix", a_out_matrix, 25'h1555555);
        a_in_data = 5'b01001;
        #1;
        check("bp_in_ready", a_in_ready, 1'b0);
        step();
        check("bp_hold_valid",  a_out_valid,  1'b1);
        check("bp_hold_matrix", a_out_matrix, 25'h1555555);
        check("bp_hold_all_eq", a_out_all_eq, 1'b0);
`ifdef REP_MATRIX_POPCNT_EN
        check("bp_hold_popcnt", a_out_popcnt, 5'd13);
`endif
        a_out_ready = 1'b1;
        #1;
        check("bp_in_ready_rel", a_in_ready, 1'b1);
        step();
        check("bp_new_valid",  a_out_valid,   1'b1);
        check("bp_new_matrix", a_out_matrix,  25'h164DAC9);
        check("bp_new_cnt",    a_uniform_cnt, 16'd2);
        a_in_valid = 1'b0;
        step();
        check("bp_drain_valid", a_out_valid, 1'b0);

        // Asynchronous reset while stalled with a held result.
        a_in_valid = 1'b1; a_in_data = 5'b11111; a_out_ready = 1'b0;
        step();
        check("pre_rst_valid", a_out_valid,   1'b1);
        check("pre_rst_cnt",   a_uniform_cnt, 16'd3);
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  a_out_valid,   1'b0);
        check("arst_matrix", a_out_matrix,  25'h0);
        check("arst_all_eq", a_out_all_eq,  1'b0);
        check("arst_cnt",    a_uniform_cnt, 16'h0);
`ifdef REP_MATRIX_POPCNT_EN
        check("arst_popcnt", a_out_popcnt,  5'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_valid", a_out_valid, 1'b0);
        check("post_rst_ready", a_in_ready,  1'b1);
        a_in_valid = 1'b1; a_in_data = 5'b01101; a_out_ready = 1'b1;
        step();
        check("post_rst_matrix", a_out_matrix,  25'h126B64D);
        check("post_rst_cnt",    a_uniform_cnt, 16'd0);
        a_in_valid = 1'b0;
        step();

        // Saturation at 7 with CNT_W=3.
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            b_in_data = k[0] ? 5'b11111 : 5'b00000;
            step();
            check($sformatf("sat_cnt_%0d", k), b_uniform_cnt, (k < 7) ? 3'(k) : 3'd7);
        end
        // Clear wins over a simultaneous all-equal acceptance.
        b_clr_cnt = 1'b1; b_in_data = 5'b00000;
        step();
        check("clr_cnt",   b_uniform_cnt, 3'd0);
        check("clr_valid", b_out_valid,   1'b1);
        b_clr_cnt = 1'b0;
        step();
        check("clr_after_inc", b_uniform_cnt, 3'd1);
        b_in_valid = 1'b0;
        step();

        // Wide channels, N=4 W=8.
        c_in_valid = 1'b1; c_in_data = 32'hAA55AA55; c_out_ready = 1'b1;
        step();
        check("w_valid",  c_out_valid,  1'b1);
        check("w_matrix", c_out_matrix, 16'hA5A5);
        check("w_all_eq", c_out_all_eq, 1'b0);
`ifdef REP_MATRIX_POPCNT_EN
        check("w_popcnt", c_out_popcnt, 5'd8);
`endif
        c_in_data = 32'h12121212;
        step();
        check("w_eq_matrix", c_out_matrix,  16'hFFFF);
        check("w_eq_all_eq", c_out_all_eq,  1'b1);
        check("w_eq_cnt",    c_uniform_cnt, 16'd1);
        c_in_valid = 1'b0;
        step();
        check("w_drain_valid", c_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
